// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider (MIPS DIV/DIVU).
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of the quotient/remainder.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  // The most negative value negates to itself, which reads correctly as unsigned.
  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule : div_sign_fix

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle,
// quotient on lo_o, remainder on hi_o, stall_div_o holds F/D/E while busy.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             adv_i,
  input  logic             annul_i,
  output logic             stall_div_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  assign w_accept = (r_state == DIV_IDLE) && start_i && !annul_i;
  assign w_last   = (r_state == DIV_BUSY) && (r_cnt == CNT_W'(WIDTH - 1));

  div_sign_fix #(.WIDTH(WIDTH)) u_a_mag (
    .i_neg (signed_i & a_i[WIDTH-1]),
    .i_val (a_i),
    .o_val (w_a_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_b_mag (
    .i_neg (signed_i & b_i[WIDTH-1]),
    .i_val (b_i),
    .o_val (w_b_mag)
  );

  // Trial subtraction in WIDTH+1 bits: a clear top bit means the divisor fit.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_rem_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

  div_sign_fix #(.WIDTH(WIDTH)) u_lo_fix (
    .i_neg (r_qneg),
    .i_val (w_quo_nxt),
    .o_val (w_lo_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_hi_fix (
    .i_neg (r_rneg),
    .i_val (w_rem_nxt),
    .o_val (w_hi_fix)
  );

  // NOTE: next state gets a default before any branch so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (annul_i) begin
      w_state_nxt = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: if (start_i) w_state_nxt = (b_i == '0) ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (w_last)  w_state_nxt = DIV_DONE;
        DIV_DONE: if (adv_i)   w_state_nxt = DIV_IDLE;
        default:               w_state_nxt = DIV_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= DIV_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= w_a_mag;
      r_div  <= w_b_mag;
      r_qneg <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      r_rneg <= signed_i & a_i[WIDTH-1];
      // Divide by zero is architecturally undefined; return a fixed pattern.
      if (b_i == '0) begin
        r_lo <= '1;
        r_hi <= a_i;
      end
    end else if ((r_state == DIV_BUSY) && !annul_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (w_last) begin
        r_lo <= w_lo_fix;
        r_hi <= w_hi_fix;
      end
    end
  end

  assign stall_div_o = !annul_i && (w_accept || (r_state == DIV_BUSY));
  assign ready_o     = !annul_i && (r_state == DIV_DONE);
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

endmodule : div_iter
